time_display_scan: RTL and testbench
====================================

# time_display_scan

Four-digit multiplexed 7-segment driver for the MM:SS clock. It sits downstream of the time counter and consumes the four BCD digit registers (min10, min01, sec10, sec01). It time-multiplexes them onto one shared active-low segment bus with per-digit active-low anode enables. It also provides anti-ghosting guard time, per-digit blinking for time-set mode, and a colon indicator.

## Interface
- SCAN_DIV, 50000: CLK1 cycles per digit slot; legal range is 4 or more.
- GUARD, 4: cycles at the start of each slot with all anodes off; legal range is 1 ≤ GUARD < SCAN_DIV.
- BLINK_FRAMES, 32: full 4-digit frames per blink half-period; legal range is 1 or more.
- CLK1  in  1  system clock; all state changes on its rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- min10  in  4  BCD tens of minutes.
- min01  in  4  BCD units of minutes.
- sec10  in  4  BCD tens of seconds.
- sec01  in  4  BCD units of seconds.
- blink_mask  in  4  bit k = 1 blinks digit k (0=sec01, 1=sec10, 2=min01, 3=min10).
- colon_en  in  1  1 = drive the decimal point on digit 2 as the colon.
- an  out  4  active-low anode enables; bit k drives digit k.
- seg  out  7  active-low segments; bit0=a … bit6=g.
- dp  out  1  active-low decimal point.

## Operation
- **Prescaler** `pcnt` counts 0..SCAN_DIV-1 and wraps.
  - At `pcnt == SCAN_DIV-1`, slot index `idx` (2 bits) advances 0→1→2→3→0.
- **Snapshot.** Four 4-bit snapshot registers load min10/min01/sec10/sec01 together on the edge where `idx` wraps 3→0.
  - Inputs are never read between snapshots, so a frame never shows a torn time.
- **Blink.** The frame counter `fcnt` counts completed frames (3→0 wraps) from 0 to BLINK_FRAMES-1.
  - At terminal count, `fcnt` wraps and `blink_ph` toggles.
- **Decode.** Snapshot digit[idx] maps to the standard segment patterns for 0–9. Values 10–15 give all segments off (`seg = 7'h7F`).
- **Anode.** `an[idx]` = 0 only if all of the following hold; otherwise `an` = 4'b1111:
  - `pcnt ≥ GUARD`;
  - not (`blink_ph` && `blink_mask[idx]`);
  - the digit is not blanked (see Configuration).
- **Colon.** `dp` = 0 only when `idx == 2`, `colon_en` = 1, and `an[2]` is driven low. Otherwise `dp` = 1.
- **Changes to `blink_mask` and `colon_en`** take effect on the next cycle's registered output. They are not snapshotted.
- **Reset** (RESETN low, asynchronous):
  - `an` = 4'b1111, `seg` = 7'h7F, `dp` = 1;
  - `pcnt` = 0, `idx` = 0, `fcnt` = 0, `blink_ph` = 0;
  - snapshots = 0.
  - The first frame after reset displays 00:00. Live inputs appear from the second frame.
- **Reset mid-slot** forces outputs dark immediately, with no glitch to any lit state.

## Timing
- `an`, `seg` and `dp` are registered: the outputs for cycle n+1 are computed from the `pcnt`, `idx`, snapshot and `blink_ph` values at cycle n.
- Slot k lasts exactly SCAN_DIV cycles.
  - `an` is all-high for the first GUARD cycles of the slot.
  - `an[k]` is low for SCAN_DIV-GUARD cycles.
- `seg` changes only during guard cycles, so it never changes while any anode is low.
- The frame period is 4×SCAN_DIV cycles. The blink half-period is BLINK_FRAMES×4×SCAN_DIV cycles.
- Input-to-display latency is at most 2 frames plus 1 cycle.
- The snapshot load and the `idx` 3→0 wrap occur on the same edge. Digit 0 of the new frame uses the new snapshot.
- The `fcnt` wrap and the `blink_ph` toggle occur on the same edge as the 3→0 wrap.

## Configuration
- **TIME_DISPLAY_LZ_BLANK_EN**
  - Defined: when the min10 snapshot is 0, digit 3 is blanked (`an[3]` stays high for the whole slot; `dp` is unaffected, since digit 3 carries no colon).
  - Undefined: a leading zero is displayed as "0".
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2.

- **Reset:** hold RESETN low, then release.
  - During reset: `an` = 1111, `seg` = 7F, `dp` = 1.
  - First frame shows 0 on every digit (`seg` = 7'h40 with `an` active; 7'h40 is the "0" pattern: segments a–f on, g off).
  - Each `an[k]` is low for 6 consecutive cycles, preceded by 2 dark cycles.
- **Snapshot:** inputs 1,2,3,4 (min10..sec01), changed to 5,9,5,9 mid-frame.
  - The current frame is unaffected.
  - The next frame shows 5,9,5,9 with no mixed digits.
- **Invalid BCD:** sec01 = 4'hC.
  - Slot 0 has `seg` = 7F.
  - The other digits are decoded normally.
- **Blink:** `blink_mask` = 0011.
  - Digits 0 and 1 are dark for frames 2–3, lit for frames 4–5, and so on.
  - Digits 2 and 3 are never blanked.
- **Colon:** `colon_en` = 1 with `blink_mask[2]` = 1.
  - `dp` = 0 only in slot 2 while `an[2]` is low.
  - `dp` = 1 during guard cycles and during blink-off phases.
- **Leading zero:** min10 = 0.
  - With TIME_DISPLAY_LZ_BLANK_EN defined, `an[3]` is never low.
  - Without it, digit 3 shows "0" (`seg` = 7'h40).

Source files
------------

// File: rtl/time_display_scan.sv
// Four-digit multiplexed 7-segment scanner for the MM:SS display, with guard time, blink and colon.
// Optional build macro TIME_DISPLAY_LZ_BLANK_EN blanks digit 3 when the tens-of-minutes digit is zero.
module time_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       CLK1,
  input  logic       RESETN,
  input  logic [3:0] min10,
  input  logic [3:0] min01,
  input  logic [3:0] sec10,
  input  logic [3:0] sec01,
  input  logic [3:0] blink_mask,
  input  logic       colon_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [FW-1:0] fcnt;
  logic          blink_ph;
  logic [3:0]    snap_m10, snap_m01, snap_s10, snap_s01;
  logic          slot_end, frame_end;
  logic [3:0]    digit;
  logic          blank;
  logic          lit;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign slot_end  = (pcnt == PW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);

  always_ff @(posedge CLK1 or negedge RESETN) begin
    if (!RESETN) begin
      pcnt     <= '0;
      idx      <= 2'd0;
      fcnt     <= '0;
      blink_ph <= 1'b0;
    end else begin
      pcnt <= slot_end ? '0 : pcnt + 1'b1;
      if (slot_end)
        idx <= idx + 2'd1;
      if (frame_end) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt     <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Inputs are captured only at the frame boundary so one frame never mixes two times.
  always_ff @(posedge CLK1 or negedge RESETN) begin
    if (!RESETN) begin
      snap_m10 <= 4'd0;
      snap_m01 <= 4'd0;
      snap_s10 <= 4'd0;
      snap_s01 <= 4'd0;
    end else if (frame_end) begin
      snap_m10 <= min10;
      snap_m01 <= min01;
      snap_s10 <= sec10;
      snap_s01 <= sec01;
    end
  end

  always_comb begin
    digit = snap_s01;
    case (idx)
      2'd0: digit = snap_s01;
      2'd1: digit = snap_s10;
      2'd2: digit = snap_m01;
      2'd3: digit = snap_m10;
      default: digit = snap_s01;
    endcase
  end

  always_comb begin
    seg_next = 7'h7F;
    case (digit)
      4'd0: seg_next = 7'h40;
      4'd1: seg_next = 7'h79;
      4'd2: seg_next = 7'h24;
      4'd3: seg_next = 7'h30;
      4'd4: seg_next = 7'h19;
      4'd5: seg_next = 7'h12;
      4'd6: seg_next = 7'h02;
      4'd7: seg_next = 7'h78;
      4'd8: seg_next = 7'h00;
      4'd9: seg_next = 7'h10;
      default: seg_next = 7'h7F;
    endcase
  end

`ifdef TIME_DISPLAY_LZ_BLANK_EN
  assign blank = (idx == 2'd3) && (snap_m10 == 4'd0);
`else
  assign blank = 1'b0;
`endif

  // Anodes stay dark for the guard window so segment changes never show as ghosting.
  always_comb begin
    lit     = (pcnt >= PW'(GUARD)) && !(blink_ph && blink_mask[idx]) && !blank;
    an_next = lit ? ~(4'b0001 << idx) : 4'b1111;
    dp_next = !((idx == 2'd2) && colon_en && lit);
  end

  always_ff @(posedge CLK1 or negedge RESETN) begin
    if (!RESETN) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench for time_display_scan: a cycle-arithmetic model checked every cycle,
// plus hand-computed spot checks at chosen frame/slot positions.
module tb_time_display_scan;

  localparam int SD    = 8;
  localparam int GD    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;
  localparam int DEPTH = 2048;

  logic       CLK1;
  logic       RESETN;
  logic [3:0] min10, min01, sec10, sec01;
  logic [3:0] blink_mask;
  logic       colon_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int compared;
  int mismatched;

  // Model state: edges since reset release, plus per-edge and per-frame input history.
  int          n;
  logic [3:0]  mask_at  [DEPTH];
  logic        colon_at [DEPTH];
  logic [15:0] snap_hist[DEPTH];
  logic [6:0]  on_pat   [10];

  time_display_scan #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
    .CLK1(CLK1), .RESETN(RESETN),
    .min10(min10), .min01(min01), .sec10(sec10), .sec01(sec01),
    .blink_mask(blink_mask), .colon_en(colon_en),
    .an(an), .seg(seg), .dp(dp)
  );

  initial begin
    CLK1 = 1'b0;
    forever #5 CLK1 = ~CLK1;
  end

  initial begin
    on_pat[0] = 7'h3F; on_pat[1] = 7'h06; on_pat[2] = 7'h5B; on_pat[3] = 7'h4F;
    on_pat[4] = 7'h66; on_pat[5] = 7'h6D; on_pat[6] = 7'h7D; on_pat[7] = 7'h07;
    on_pat[8] = 7'h7F; on_pat[9] = 7'h6F;
  end

  always @(posedge CLK1) begin
    if (!RESETN) begin
      n = 0;
      snap_hist[0] = 16'h0000;
    end else begin
      n = n + 1;
      if (n < DEPTH) begin
        mask_at[n]  = blink_mask;
        colon_at[n] = colon_en;
        if (n % FRAME == 0)
          snap_hist[n / FRAME] = {min10, min01, sec10, sec01};
      end
    end
  end

  task automatic computeExpected(input int nn, output logic [3:0] ea, output logic [6:0] es,
                                 output logic ed);
    int s, p, k, f;
    logic ph, lit, blank;
    logic [3:0] d;
    s = nn - 1;
    p = s % SD;
    k = (s / SD) % 4;
    f = s / FRAME;
    ph = ((f / BF) % 2) == 1;
    d = 4'((snap_hist[f] >> (4 * k)) & 16'hF);
`ifdef TIME_DISPLAY_LZ_BLANK_EN
    blank = (k == 3) && (d == 4'd0);
`else
    blank = 1'b0;
`endif
    lit = (p >= GD) && !(ph && mask_at[nn][k]) && !blank;
    es  = (d <= 4'd9) ? ~on_pat[d] : 7'h7F;
    ea  = lit ? ~(4'b0001 << k) : 4'b1111;
    ed  = (k == 2 && colon_at[nn] && lit) ? 1'b0 : 1'b1;
  endtask

  task automatic compare3(input string name, input logic [3:0] ea, input logic [6:0] es,
                          input logic ed);
    compared = compared + 1;
    if (an !== ea || seg !== es || dp !== ed) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s at t=%0t n=%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, $time, n, an, seg, dp, ea, es, ed);
    end
  endtask

  // Every cycle, the outputs must match what the model derives from elapsed cycles and history.
  always @(negedge CLK1) begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    if (!RESETN || n == 0) begin
      compare3("model_dark", 4'b1111, 7'h7F, 1'b1);
    end else if (n < DEPTH) begin
      computeExpected(n, ea, es, ed);
      compare3("model", ea, es, ed);
    end
  end

  task automatic waitUntil(input int target);
    int guard_cnt;
    guard_cnt = 0;
    while (n != target && guard_cnt < 1000) begin
      @(negedge CLK1);
      guard_cnt++;
    end
    if (n != target) begin
      compared   = compared + 1;
      mismatched = mismatched + 1;
      $display("[TB] FAIL wait_timeout: got n=%0d, expected n=%0d", n, target);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] m10, input logic [3:0] m01, input logic [3:0] s10,
                               input logic [3:0] s01, input logic [3:0] mask, input logic col);
    min10      = m10;
    min01      = m01;
    sec10      = s10;
    sec01      = s01;
    blink_mask = mask;
    colon_en   = col;
  endtask

  task automatic checkOutput(input string name, input int target, input logic [3:0] ea,
                             input logic [6:0] es, input logic ed);
    waitUntil(target);
    compare3(name, ea, es, ed);
  endtask

  function automatic int at(input int frame, input int slot, input int p);
    return frame * FRAME + slot * SD + p + 1;
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    n          = 0;
    snap_hist[0] = 16'h0000;
    RESETN = 1'b1;
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    #1 RESETN = 1'b0;
    repeat (3) @(negedge CLK1);
    compare3("reset_dark", 4'b1111, 7'h7F, 1'b1);
    RESETN = 1'b1;

    checkOutput("f0_slot0_zero",   at(0, 0, 4), 4'b1110, 7'h40, 1'b1);
    checkOutput("f0_slot1_guard",  at(0, 1, 0), 4'b1111, 7'h40, 1'b1);
    checkOutput("f0_slot2_zero",   at(0, 2, 4), 4'b1011, 7'h40, 1'b1);
    checkOutput("f1_slot0_four",   at(1, 0, 4), 4'b1110, 7'h19, 1'b1);

    waitUntil(at(1, 1, 3));
    applyStimulus(4'd5, 4'd9, 4'd5, 4'd9, 4'b0000, 1'b0);
    checkOutput("f1_slot3_untorn", at(1, 3, 4), 4'b0111, 7'h79, 1'b1);
    checkOutput("f2_slot0_nine",   at(2, 0, 4), 4'b1110, 7'h10, 1'b1);

    waitUntil(at(2, 0, 5));
    applyStimulus(4'd5, 4'd9, 4'd5, 4'hC, 4'b0000, 1'b0);
    checkOutput("f2_slot3_five",   at(2, 3, 4), 4'b0111, 7'h12, 1'b1);
    checkOutput("f3_slot0_badbcd", at(3, 0, 4), 4'b1110, 7'h7F, 1'b1);
    checkOutput("f3_slot1_five",   at(3, 1, 4), 4'b1101, 7'h12, 1'b1);

    waitUntil(at(3, 1, 5));
    applyStimulus(4'd5, 4'd9, 4'd5, 4'hC, 4'b0011, 1'b0);
    checkOutput("f4_slot1_blinkon",  at(4, 1, 4), 4'b1101, 7'h12, 1'b1);
    checkOutput("f6_slot0_blinkoff", at(6, 0, 4), 4'b1111, 7'h7F, 1'b1);
    checkOutput("f6_slot2_steady",   at(6, 2, 4), 4'b1011, 7'h10, 1'b1);

    waitUntil(at(7, 0, 5));
    applyStimulus(4'd5, 4'd9, 4'd5, 4'hC, 4'b0100, 1'b1);
    checkOutput("f8_slot2_guard_dp", at(8, 2, 0), 4'b1111, 7'h10, 1'b1);
    checkOutput("f8_slot2_colon",    at(8, 2, 4), 4'b1011, 7'h10, 1'b0);
    checkOutput("f10_slot2_blinkdp", at(10, 2, 4), 4'b1111, 7'h10, 1'b1);

    waitUntil(at(10, 3, 0));
    applyStimulus(4'd0, 4'd9, 4'd5, 4'hC, 4'b0100, 1'b1);
`ifdef TIME_DISPLAY_LZ_BLANK_EN
    checkOutput("f11_slot3_lzblank", at(11, 3, 4), 4'b1111, 7'h40, 1'b1);
`else
    checkOutput("f11_slot3_lzzero",  at(11, 3, 4), 4'b0111, 7'h40, 1'b1);
`endif

    checkOutput("f12_slot0_lit",     at(12, 0, 4), 4'b1110, 7'h7F, 1'b1);
    #2 RESETN = 1'b0;
    #1 compare3("midslot_reset_dark", 4'b1111, 7'h7F, 1'b1);
    @(negedge CLK1);
    RESETN = 1'b1;
    checkOutput("rst2_slot0_zero",   at(0, 0, 4), 4'b1110, 7'h40, 1'b1);
    waitUntil(at(1, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
